// File: rtl/stack_ctrl.sv
// Push/pop sequencer between the control unit, stack memory and the SP register.
// Optional bounds checking is enabled by defining STACK_BOUNDS_CHECK_EN.
module stack_ctrl #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] STACK_TOP   = 16'hFFFF,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 16'hF000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_req,
    input  logic              pop_req,
    input  logic [DATA_W-1:0] push_data,
    input  logic [ADDR_W-1:0] sp_in,
    output logic              sp_push,
    output logic              sp_pop,
    output logic [ADDR_W-1:0] sp_new_val,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] pop_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH_WR,
        POP_RD,
        SP_UPD
`ifdef STACK_BOUNDS_CHECK_EN
        , ERR
`endif
    } state_t;

    // A limit above the top leaves no legal push address at all.
    if (STACK_LIMIT > STACK_TOP) begin : g_bad_cfg
        $error("stack_ctrl: STACK_LIMIT must not exceed STACK_TOP");
    end

    state_t            state, state_n;
    logic [ADDR_W-1:0] sp_q, sp_q_n;
    logic [ADDR_W-1:0] sp_new_val_n, mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n, pop_data_n;
    logic              sp_push_n, sp_pop_n, mem_we_n, mem_re_n, busy_n, done_n;
    logic              err_n;

    // Outputs are registered copies of the values the next state needs.
    always_comb begin
        state_n      = state;
        sp_q_n       = sp_q;
        sp_new_val_n = sp_new_val;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        pop_data_n   = pop_data;
        sp_push_n    = 1'b0;
        sp_pop_n     = 1'b0;
        mem_we_n     = 1'b0;
        mem_re_n     = 1'b0;
        done_n       = 1'b0;
        err_n        = 1'b0;

        case (state)
            IDLE: begin
                if (push_req) begin
                    sp_q_n = sp_in;
`ifdef STACK_BOUNDS_CHECK_EN
                    if (sp_in < STACK_LIMIT) begin
                        state_n = ERR;
                        err_n   = 1'b1;
                        done_n  = 1'b1;
                    end else
`endif
                    begin
                        state_n     = PUSH_WR;
                        mem_we_n    = 1'b1;
                        mem_addr_n  = sp_in;
                        mem_wdata_n = push_data;
                    end
                end else if (pop_req) begin
                    sp_q_n = sp_in;
`ifdef STACK_BOUNDS_CHECK_EN
                    if (sp_in == STACK_TOP) begin
                        state_n = ERR;
                        err_n   = 1'b1;
                        done_n  = 1'b1;
                    end else
`endif
                    begin
                        state_n    = POP_RD;
                        mem_re_n   = 1'b1;
                        mem_addr_n = sp_in + 1'b1;
                    end
                end
            end
            PUSH_WR: begin
                if (mem_ready) begin
                    state_n      = SP_UPD;
                    sp_push_n    = 1'b1;
                    done_n       = 1'b1;
                    sp_new_val_n = sp_q - 1'b1;
                end else begin
                    mem_we_n = 1'b1;
                end
            end
            POP_RD: begin
                if (mem_ready) begin
                    state_n      = SP_UPD;
                    sp_pop_n     = 1'b1;
                    done_n       = 1'b1;
                    sp_new_val_n = sp_q + 1'b1;
                    pop_data_n   = mem_rdata;
                end else begin
                    mem_re_n = 1'b1;
                end
            end
            SP_UPD:  state_n = IDLE;
`ifdef STACK_BOUNDS_CHECK_EN
            ERR:     state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sp_q       <= '0;
            sp_new_val <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            pop_data   <= '0;
            sp_push    <= 1'b0;
            sp_pop     <= 1'b0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            sp_q       <= sp_q_n;
            sp_new_val <= sp_new_val_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            pop_data   <= pop_data_n;
            sp_push    <= sp_push_n;
            sp_pop     <= sp_pop_n;
            mem_we     <= mem_we_n;
            mem_re     <= mem_re_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

`ifdef STACK_BOUNDS_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) err <= 1'b0;
        else       err <= err_n;
    end
`else
    logic err_unused;
    assign err_unused = err_n;
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed self-checking bench for stack_ctrl; outputs sampled on the falling edge.
module tb_stack_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        push_req = 1'b0, pop_req = 1'b0, mem_ready = 1'b0;
    logic [15:0] push_data = '0, sp_in = '0, mem_rdata = '0;
    logic        sp_push, sp_pop, mem_we, mem_re, busy, done, err;
    logic [15:0] sp_new_val, mem_addr, mem_wdata, pop_data;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    stack_ctrl #(.DATA_W(16), .ADDR_W(16), .STACK_TOP(16'hFFFF), .STACK_LIMIT(16'hF000)) dut (
        .clk(clk), .reset(reset), .push_req(push_req), .pop_req(pop_req),
        .push_data(push_data), .sp_in(sp_in), .sp_push(sp_push), .sp_pop(sp_pop),
        .sp_new_val(sp_new_val), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pop_data(pop_data), .busy(busy), .done(done), .err(err)
    );

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({sp_push, sp_pop, mem_we, mem_re, busy, done, err} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 0000000", {sp_push, sp_pop, mem_we, mem_re, busy, done, err});
        end
        tests++;
        if ({mem_addr, mem_wdata, sp_new_val, pop_data} !== 64'h0) begin
            fails++;
            $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, sp_new_val, pop_data});
        end
        reset = 1'b0;
    endtask

    task automatic test_push;
        push_req = 1'b1; push_data = 16'hABCD; sp_in = 16'hFFFF; mem_ready = 1'b1;
        @(negedge clk);
        push_req = 1'b0;
        tests++;
        if ({mem_we, mem_re, busy, mem_addr, mem_wdata} !== {3'b101, 16'hFFFF, 16'hABCD}) begin
            fails++;
            $display("FAIL push_access: got we=%b re=%b busy=%b addr=%h wd=%h want 1 0 1 ffff abcd",
                     mem_we, mem_re, busy, mem_addr, mem_wdata);
        end
        @(negedge clk);
        tests++;
        if ({sp_push, sp_pop, done, mem_we, sp_new_val} !== {4'b1010, 16'hFFFE}) begin
            fails++;
            $display("FAIL push_strobe: got push=%b pop=%b done=%b we=%b nv=%h want 1 0 1 0 fffe",
                     sp_push, sp_pop, done, mem_we, sp_new_val);
        end
        @(negedge clk);
        tests++;
        if ({sp_push, done, busy} !== 3'b000) begin
            fails++;
            $display("FAIL push_idle: got push=%b done=%b busy=%b want 000", sp_push, done, busy);
        end
    endtask

    task automatic test_pop_wait;
        pop_req = 1'b1; sp_in = 16'hFFFE; mem_rdata = 16'h1234; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pop_req = 1'b0;
            tests++;
            if ({mem_re, mem_we, sp_pop, done, mem_addr} !== {4'b1000, 16'hFFFF}) begin
                fails++;
                $display("FAIL pop_wait[%0d]: got re=%b we=%b pop=%b done=%b addr=%h want 1 0 0 0 ffff",
                         i, mem_re, mem_we, sp_pop, done, mem_addr);
            end
        end
        mem_ready = 1'b1;
        @(negedge clk);
        tests++;
        if ({sp_pop, sp_push, done, mem_re, sp_new_val, pop_data} !== {4'b1010, 16'hFFFF, 16'h1234}) begin
            fails++;
            $display("FAIL pop_strobe: got pop=%b push=%b done=%b re=%b nv=%h pd=%h want 1 0 1 0 ffff 1234",
                     sp_pop, sp_push, done, mem_re, sp_new_val, pop_data);
        end
        @(negedge clk);
        tests++;
        if ({busy, pop_data} !== {1'b0, 16'h1234}) begin
            fails++;
            $display("FAIL pop_hold: got busy=%b pd=%h want 0 1234", busy, pop_data);
        end
    endtask

    task automatic test_push_pop_priority;
        int unsigned n_push = 0, n_pop = 0, n_re = 0;
        logic [15:0] nv = '0;
        push_req = 1'b1; pop_req = 1'b1; sp_in = 16'h8000; push_data = 16'h5A5A; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                push_req = 1'b0; pop_req = 1'b0;
                tests++;
                if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h8000, 16'h5A5A}) begin
                    fails++;
                    $display("FAIL both_access: got we=%b addr=%h wd=%h want 1 8000 5a5a",
                             mem_we, mem_addr, mem_wdata);
                end
            end
            if (sp_push) begin n_push++; nv = sp_new_val; end
            if (sp_pop) n_pop++;
            if (mem_re) n_re++;
        end
        tests++;
        if (n_push != 1 || n_pop != 0 || n_re != 0 || nv !== 16'h7FFF) begin
            fails++;
            $display("FAIL both_priority: got push=%0d pop=%0d re=%0d nv=%h want 1 0 0 7fff",
                     n_push, n_pop, n_re, nv);
        end
    endtask

    task automatic test_reset_mid;
        int unsigned n_ev = 0;
        push_req = 1'b1; sp_in = 16'hF800; push_data = 16'h0F0F; mem_ready = 1'b0;
        @(negedge clk);
        push_req = 1'b0;
        tests++;
        if (mem_we !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_pre: got we=%b want 1", mem_we);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({mem_we, busy, done, sp_push} !== 4'b0000) begin
            fails++;
            $display("FAIL rst_mid_abort: got we=%b busy=%b done=%b push=%b want 0000",
                     mem_we, busy, done, sp_push);
        end
        reset = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (sp_push || done || mem_we) n_ev++;
        end
        tests++;
        if (n_ev != 0) begin
            fails++;
            $display("FAIL rst_mid_lost: got %0d activity cycles want 0", n_ev);
        end
    endtask

    task automatic test_push_at_limit;
        push_req = 1'b1; sp_in = 16'hF000; push_data = 16'h7777; mem_ready = 1'b1;
        @(negedge clk);
        push_req = 1'b0;
        @(negedge clk);
        tests++;
        if ({sp_push, err, sp_new_val} !== {2'b10, 16'hEFFF}) begin
            fails++;
            $display("FAIL push_limit: got push=%b err=%b nv=%h want 1 0 efff", sp_push, err, sp_new_val);
        end
        @(negedge clk);
    endtask

`ifdef STACK_BOUNDS_CHECK_EN
    task automatic test_bounds;
        logic [15:0] sp_vals [2];
        sp_vals[0] = 16'hFFFF;
        sp_vals[1] = 16'hEFFF;
        for (int k = 0; k < 2; k++) begin
            pop_req = (k == 0); push_req = (k == 1); sp_in = sp_vals[k]; mem_ready = 1'b1;
            @(negedge clk);
            pop_req = 1'b0; push_req = 1'b0;
            tests++;
            if ({err, done, mem_re, mem_we, sp_push, sp_pop} !== 6'b110000) begin
                fails++;
                $display("FAIL bounds_err[%0d]: got %b want 110000", k,
                         {err, done, mem_re, mem_we, sp_push, sp_pop});
            end
            @(negedge clk);
            tests++;
            if ({err, done, busy, sp_push, sp_pop, pop_data} !== {5'b00000, 16'h1234}) begin
                fails++;
                $display("FAIL bounds_after[%0d]: got %b pd=%h want 00000 1234", k,
                         {err, done, busy, sp_push, sp_pop}, pop_data);
            end
        end
    endtask
`else
    task automatic test_bounds;
        int unsigned n_err = 0;
        pop_req = 1'b1; sp_in = 16'hFFFF; mem_rdata = 16'h4321; mem_ready = 1'b1;
        @(negedge clk);
        pop_req = 1'b0;
        if (err) n_err++;
        tests++;
        if ({mem_re, mem_addr} !== {1'b1, 16'h0000}) begin
            fails++;
            $display("FAIL wrap_access: got re=%b addr=%h want 1 0000", mem_re, mem_addr);
        end
        @(negedge clk);
        if (err) n_err++;
        tests++;
        if ({sp_pop, sp_new_val, pop_data} !== {1'b1, 16'h0000, 16'h4321}) begin
            fails++;
            $display("FAIL wrap_strobe: got pop=%b nv=%h pd=%h want 1 0000 4321", sp_pop, sp_new_val, pop_data);
        end
        @(negedge clk);
        if (err) n_err++;
        tests++;
        if (n_err != 0) begin
            fails++;
            $display("FAIL wrap_err: got %0d err cycles want 0", n_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_push();
        test_pop_wait();
        test_push_pop_priority();
        test_reset_mid();
        test_push_at_limit();
        test_bounds();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Sequencer directly upstream of the stack pointer register.
- Accepts push/pop requests from the control unit and performs the data-memory write or read at the stack address.
- Drives the SP register's push/pop strobes and new value.
- Stack grows downward from STACK_TOP (the SP reset value 16'hFFFF). SP always points to the next free slot.

Parameters:
- DATA_W, 16, width of stack data words.
- ADDR_W, 16, width of SP and memory address.
- STACK_TOP, 16'hFFFF, highest stack address; equals the SP reset value.
- STACK_LIMIT, 16'hF000, lowest address a push may write.

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  synchronous, active-high reset
push_req  input  1  request push of push_data; sampled only in IDLE
pop_req  input  1  request pop; sampled only in IDLE
push_data  input  DATA_W  data to push; captured on accept
sp_in  input  ADDR_W  current SP register output; captured on accept
sp_push  output  1  one-cycle strobe to SP register push input
sp_pop  output  1  one-cycle strobe to SP register pop input
sp_new_val  output  ADDR_W  value SP is to load; valid while either strobe is high
mem_addr  output  ADDR_W  stack memory address
mem_wdata  output  DATA_W  stack memory write data
mem_we  output  1  memory write enable
mem_re  output  1  memory read enable
mem_rdata  input  DATA_W  memory read data; valid when mem_ready=1 during a read
mem_ready  input  1  memory completes the current access in this cycle
pop_data  output  DATA_W  last popped word; held until the next successful pop
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse at completion of each accepted request
err  output  1  one-cycle pulse on bounds violation (see Optional Feature)

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high) sets: state=IDLE; every strobe, enable and pulse = 0; mem_addr, mem_wdata, sp_new_val, pop_data = 0.
- Reset mid-operation aborts immediately:
  - mem_we/mem_re drop the next cycle.
  - No SP strobe is issued.
  - The pending request is lost.
- States: IDLE, PUSH_WR, POP_RD, SP_UPD, ERR.
- IDLE:
  - push_req=1 → capture sp_in into sp_q and push_data; go to PUSH_WR.
  - Else pop_req=1 → capture sp_q; go to POP_RD.
  - Both high → push wins; the pop is dropped, not queued.
- PUSH_WR:
  - mem_we=1, mem_addr=sp_q, mem_wdata=captured data.
  - Hold until mem_ready=1, then go to SP_UPD with sp_new_val=sp_q-1.
- POP_RD:
  - mem_re=1, mem_addr=sp_q+1.
  - Hold until mem_ready=1, then latch mem_rdata into pop_data and go to SP_UPD with sp_new_val=sp_q+1.
- SP_UPD:
  - Exactly one of sp_push/sp_pop is high for exactly one clk.
  - done=1 in the same cycle.
  - Next state is IDLE.
- ERR: err=1 and done=1 for one cycle; no memory access; no SP strobe; next state IDLE.
- Latency: with mem_ready held high, accept at cycle N → memory access at N+1 → strobe and done at N+2. The next request can be accepted at N+3.
- Each wait cycle with mem_ready=0 adds one cycle. Address, data and enables stay stable while waiting.
- Requests arriving while busy=1 are ignored. The requester must hold the request until it sees done.
- Arithmetic is modulo 2^ADDR_W.
- mem_we and mem_re are never high together. sp_push and sp_pop are never high together.

Optional Feature:
- Macro: STACK_BOUNDS_CHECK_EN.
- Defined:
  - A push accepted with sp_in < STACK_LIMIT, or a pop accepted with sp_in == STACK_TOP, goes to ERR instead of PUSH_WR/POP_RD.
  - SP and memory are untouched and pop_data keeps its value.
- Undefined:
  - No checks are made; err is tied 0 and the ERR state is not compiled.
  - SP wraps: a pop at 16'hFFFF reads address 16'h0000 and loads 16'h0000.

Test Plan:
- Reset then push_req with push_data=16'hABCD, sp_in=16'hFFFF, mem_ready=1 → N+1: mem_we=1, mem_addr=FFFF, mem_wdata=ABCD; N+2: sp_push=1, sp_new_val=FFFE, done=1.
- Pop with sp_in=16'hFFFE, mem_rdata=16'h1234, mem_ready low for 3 cycles → mem_re and mem_addr=FFFF held 4 cycles; then sp_pop=1, sp_new_val=FFFF, pop_data=1234.
- push_req and pop_req high together in IDLE with sp_in=16'h8000 → push sequence only; sp_push pulses with sp_new_val=7FFF; no sp_pop at any point.
- Reset asserted during PUSH_WR wait → next cycle mem_we=0, busy=0; no sp_push or done ever issued.
- With STACK_BOUNDS_CHECK_EN, pop at sp_in=FFFF → err=1 and done=1 at N+1; no mem_re, no strobe. Push at sp_in=16'hEFFF (below limit) behaves the same.
- Without the macro, pop at sp_in=FFFF → mem_addr=0000, sp_new_val=0000, err stays 0.
